mult_div_unit: RTL and testbench

- Multi-cycle HI/LO multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the one-cycle `start` pulse and the EX-stage operands.
- Produces `busy` (fed back to start generation and the stall logic) and the architectural HI/LO registers read by mfhi/mflo.
- Models fixed hardware latency; results become visible only when `busy` falls.

---
 rtl/mult_div_unit_pkg.sv | 20 ++
 rtl/mult_div_unit_md_arith.sv | 49 ++++
 rtl/mult_div_unit.sv | 103 ++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - opcodes, latency defaults and FSM state type for the HI/LO unit
package mult_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Wide enough for any sensible latency setting.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// rtl/mult_div_unit_md_arith.sv - combinational 32x32 multiply/divide datapath
// Ports:
//   md_op    : 00 mult, 01 multu, 10 div, 11 divu
//   A, B     : operands (A is the dividend)
//   hi_res   : product[63:32] or remainder
//   lo_res   : product[31:0] or quotient
//   div_zero : divide op with B == 0
import mult_div_unit_pkg::*;

module md_arith (
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    // md_op[0] selects unsigned; signed ops sign-extend, unsigned ops zero-extend.
    logic        w_sx_a;
    logic        w_sx_b;
    logic [63:0] w_prod;
    logic signed [32:0] w_da;
    logic signed [32:0] w_db;

    always_comb begin
        w_sx_a   = ~md_op[0] & A[31];
        w_sx_b   = ~md_op[0] & B[31];
        div_zero = md_op[1] & (B == 32'd0);

        // The low 64 bits of a 64x64 product are exact for both signednesses.
        w_prod = {{32{w_sx_a}}, A} * {{32{w_sx_b}}, B};

        // 33-bit signed division covers unsigned operands and makes
        // 0x80000000 / -1 representable (low word wraps to 0x80000000).
        // Divisor forced to 1 on divide-by-zero so the result is defined;
        // the top level discards it anyway.
        w_da = {w_sx_a, A};
        w_db = div_zero ? 33'sd1 : {w_sx_b, B};

        hi_res = w_prod[63:32];
        lo_res = w_prod[31:0];
        if (md_op[1]) begin
            lo_res = 32'(w_da / w_db);
            hi_res = 32'(w_da % w_db);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit with fixed latency
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start, md_op   : one-cycle request and operation, sampled when idle
//   A, B           : operands (A also feeds mthi/mtlo)
//   mthi, mtlo     : direct writes of A into HI/LO when idle and not starting
//   busy           : operation in flight
//   HI, LO         : architectural HI/LO registers
import mult_div_unit_pkg::*;

module mult_div_unit #(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_zero;

    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;
    logic               w_div_zero;

    md_arith u_arith (
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .hi_res   (w_hi_res),
        .lo_res   (w_lo_res),
        .div_zero (w_div_zero)
    );

    // The result is computed at accept time; the counter only models latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pend_hi   <= '0;
            r_pend_lo   <= '0;
            r_pend_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // start takes priority over a same-cycle mthi/mtlo.
                        r_pend_hi   <= w_hi_res;
                        r_pend_lo   <= w_lo_res;
                        r_pend_zero <= w_div_zero;
                        r_count     <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                    end else begin
                        if (mthi) r_hi <= A;
                        if (mtlo) r_lo <= A;
                    end
                end
                ST_RUN: begin
                    if (r_count == CNT_W'(1)) begin
                        // Divide-by-zero leaves HI/LO untouched.
                        if (!r_pend_zero) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_count <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed self-checking bench for mult_div_unit
import mult_div_unit_pkg::*;

module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural HI/LO, cycles of busy still owed, and the
    // result that becomes visible once those cycles have elapsed.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    logic [31:0] m_res_hi = '0;
    logic [31:0] m_res_lo = '0;
    logic        m_res_keep = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        longint r;
        m_res_keep = 1'b0;
        case (o)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_res_hi = p[63:32];
                m_res_lo = p[31:0];
            end
            MD_MULTU: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                m_res_hi = p[63:32];
                m_res_lo = p[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) m_res_keep = 1'b1;
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_res_lo = q[31:0];
                    m_res_hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) m_res_keep = 1'b1;
                else begin
                    q = longint'({32'd0, a}) / longint'({32'd0, b});
                    r = longint'({32'd0, a}) % longint'({32'd0, b});
                    m_res_lo = q[31:0];
                    m_res_hi = r[31:0];
                end
            end
        endcase
    endtask

    // One clock: drive, let the edge happen, advance the reference, compare.
    task automatic step(input logic r, input logic s, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic h, input logic l);
        reset = r; start = s; md_op = o; A = a; B = b; mthi = h; mtlo = l;
        @(posedge clk);
        if (r) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_res_keep) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (s) begin
            compute(o, a, b);
            m_left = o[1] ? DEF_DIV_CYCLES : DEF_MULT_CYCLES;
        end else begin
            if (h) m_hi = a;
            if (l) m_lo = a;
        end
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
    endtask

    task automatic idle(input logic h, input logic l, input logic [31:0] a);
        step(1'b0, 1'b0, 2'b00, a, 32'd0, h, l);
    endtask

    // Start an op, then idle until busy drops; returns the busy length seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic l_with_start, input logic h_while_busy, output int n);
        step(1'b0, 1'b1, o, a, b, 1'b0, l_with_start);
        n = 0;
        while (busy && n < 30) begin
            n++;
            idle(h_while_busy, 1'b0, 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        reset = 1'b1; start = 1'b0; md_op = 2'b00; A = '0; B = '0; mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);

        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);

        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, n);
        check("mult_busy_len", n, 32'd5);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFFA);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
        check("multu_busy_len", n, 32'd5);
        check("multu_HI", HI, 32'hFFFF_FFFE);
        check("multu_LO", LO, 32'h0000_0001);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
        check("div_busy_len", n, 32'd10);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);

        idle(1'b1, 1'b0, 32'h12);
        idle(1'b0, 1'b1, 32'h34);
        run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, n);
        check("divz_busy_len", n, 32'd10);
        check("divz_HI", HI, 32'h12);
        check("divz_LO", LO, 32'h34);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
        check("divovf_LO", LO, 32'h8000_0000);
        check("divovf_HI", HI, 32'h0);

        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, 1'b1, n);
        check("mthi_busy_HI", HI, 32'd0);
        check("mthi_busy_LO", LO, 32'd12);

        run_op(MD_MULTU, 32'd6, 32'd7, 1'b1, 1'b0, n);
        check("mtlo_start_LO", LO, 32'd42);
        check("mtlo_start_HI", HI, 32'd0);

        idle(1'b1, 1'b1, 32'h5555_AAAA);
        check("mthi_mtlo_HI", HI, 32'h5555_AAAA);
        check("mthi_mtlo_LO", LO, 32'h5555_AAAA);

        step(1'b0, 1'b1, MD_DIV, 32'd10, 32'd3, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_HI", HI, 32'd0);
        for (int i = 0; i < 12; i++) idle(1'b0, 1'b0, 32'd0);
        check("abort_late_HI", HI, 32'd0);
        check("abort_late_LO", LO, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 9);
                default: ;
            endcase
            rs = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 199) == 0), rs, 2'($urandom_range(0, 3)), ra, rb,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
